// File: rtl/ghr_index_gen.sv
// Global-history branch index generator with an in-flight entry FIFO for training and recovery.
// Define GHR_GSHARE_XOR_EN to hash the history with pred_pc[K+1:2]; otherwise the history alone indexes the table.
module ghr_index_gen #(
  parameter int K     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pred_valid,
  input  logic [31:0]              pred_pc,
  input  logic                     pred_taken,
  output logic                     pred_ready,
  output logic [K-1:0]             lookup_index,
  input  logic                     res_valid,
  input  logic                     res_taken,
  output logic                     res_ready,
  output logic                     upd_valid,
  output logic [K-1:0]             upd_index,
  output logic                     upd_outcome,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int              AW     = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]     OCC_1  = (AW+1)'(1);
  localparam logic [AW-1:0]   PTR_1  = AW'(1);

  logic [K-1:0]  ghr_r;
  logic [AW-1:0] head_r;
  logic [AW-1:0] tail_r;
  logic [AW:0]   occ_r;
  logic          upd_valid_r;
  logic [K-1:0]  upd_index_r;
  logic          upd_outcome_r;
  logic          mispredict_r;

  logic [K-1:0]  idx_mem_r  [DEPTH];
  logic [K-1:0]  ghr_mem_r  [DEPTH];
  logic          pred_mem_r [DEPTH];

  logic          push_s;
  logic          pop_s;
  logic          mispred_s;
  logic          wr_s;
  logic          pc_unused_s;

`ifdef GHR_GSHARE_XOR_EN
  assign lookup_index = ghr_r ^ pred_pc[K+1:2];
`else
  assign lookup_index = ghr_r;
`endif
  assign pc_unused_s = ^pred_pc;

  assign pred_ready = (occ_r != FULL_C);
  assign res_ready  = (occ_r != {(AW+1){1'b0}});
  assign push_s     = pred_valid & pred_ready;
  assign pop_s      = res_valid & res_ready;
  assign mispred_s  = pop_s & (res_taken != pred_mem_r[head_r]);
  // A mispredict flushes the FIFO, so a same-cycle push must never land.
  assign wr_s       = push_s & ~mispred_s;

  assign upd_valid   = upd_valid_r;
  assign upd_index   = upd_index_r;
  assign upd_outcome = upd_outcome_r;
  assign mispredict  = mispredict_r;
  assign occupancy   = occ_r;

  // Entry storage: index, prediction and the history seen at lookup time.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      idx_mem_r[tail_r]  <= lookup_index;
      pred_mem_r[tail_r] <= pred_taken;
      ghr_mem_r[tail_r]  <= ghr_r;
    end
  end

  // History, pointers, occupancy and the one-cycle update/recovery outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_r         <= '0;
      head_r        <= '0;
      tail_r        <= '0;
      occ_r         <= '0;
      upd_valid_r   <= 1'b0;
      upd_index_r   <= '0;
      upd_outcome_r <= 1'b0;
      mispredict_r  <= 1'b0;
    end else begin
      upd_valid_r  <= pop_s;
      mispredict_r <= mispred_s;
      if (pop_s) begin
        upd_index_r   <= idx_mem_r[head_r];
        upd_outcome_r <= res_taken;
      end else begin
        upd_index_r   <= upd_index_r;
        upd_outcome_r <= upd_outcome_r;
      end
      if (mispred_s) begin
        // Rebuild history from the snapshot of the wrong branch plus its real outcome.
        ghr_r  <= {ghr_mem_r[head_r][K-2:0], res_taken};
        head_r <= '0;
        tail_r <= '0;
        occ_r  <= '0;
      end else begin
        if (push_s) begin
          ghr_r  <= {ghr_r[K-2:0], pred_taken};
          tail_r <= tail_r + PTR_1;
        end else begin
          ghr_r  <= ghr_r;
          tail_r <= tail_r;
        end
        if (pop_s) begin
          head_r <= head_r + PTR_1;
        end else begin
          head_r <= head_r;
        end
        case ({push_s, pop_s})
          2'b10:   occ_r <= occ_r + OCC_1;
          2'b01:   occ_r <= occ_r - OCC_1;
          default: occ_r <= occ_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ghr_index_gen.sv
// Self-checking bench for ghr_index_gen: queue-based reference model, directed scenarios, random traffic.
module tb_ghr_index_gen;
  localparam int K     = 4;
  localparam int DEPTH = 4;
  localparam int MASK  = (1 << K) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pred_valid = 1'b0;
  logic [31:0] pred_pc = 32'd0;
  logic        pred_taken = 1'b0;
  logic        pred_ready;
  logic [K-1:0] lookup_index;
  logic        res_valid = 1'b0;
  logic        res_taken = 1'b0;
  logic        res_ready;
  logic        upd_valid;
  logic [K-1:0] upd_index;
  logic        upd_outcome;
  logic        mispredict;
  logic [$clog2(DEPTH):0] occupancy;

  ghr_index_gen #(.K(K), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_ready(pred_ready), .lookup_index(lookup_index),
    .res_valid(res_valid), .res_taken(res_taken), .res_ready(res_ready),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_outcome(upd_outcome),
    .mispredict(mispredict), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit pred;
    int ghr;
  } ent_t;

  ent_t q[$];
  int   ghr_m;
  bit   exp_uv, exp_mis, exp_uo;
  int   exp_ui;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int model_idx(int g, logic [31:0] pc);
`ifdef GHR_GSHARE_XOR_EN
    return (g ^ int'(pc >> 2)) & MASK;
`else
    return g & MASK;
`endif
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    ghr_m   = 0;
    exp_uv  = 1'b0;
    exp_mis = 1'b0;
    exp_ui  = 0;
    exp_uo  = 1'b0;
  endtask

  // Compare every DUT output against the model for the current cycle.
  task automatic check_all();
    chk("lookup_index", int'(lookup_index), model_idx(ghr_m, pred_pc));
    chk("pred_ready", int'(pred_ready), int'(q.size() != DEPTH));
    chk("res_ready", int'(res_ready), int'(q.size() != 0));
    chk("occupancy", int'(occupancy), q.size());
    chk("upd_valid", int'(upd_valid), int'(exp_uv));
    chk("mispredict", int'(mispredict), int'(exp_mis));
    if (exp_uv) begin
      chk("upd_index", int'(upd_index), exp_ui);
      chk("upd_outcome", int'(upd_outcome), int'(exp_uo));
    end
  endtask

  // Called just after a falling edge: drive inputs, then check.
  task automatic apply(bit pv, logic [31:0] pc, bit pt, bit rv, bit rt);
    pred_valid = pv;
    pred_pc    = pc;
    pred_taken = pt;
    res_valid  = rv;
    res_taken  = rt;
    #1;
    check_all();
  endtask

  // Advance the model by the rules, then the DUT by one clock.
  task automatic advance();
    bit   push, pop, mis;
    ent_t h;
    ent_t e;
    push = pred_valid && (q.size() != DEPTH);
    pop  = res_valid && (q.size() != 0);
    mis  = 1'b0;
    exp_uv = pop;
    if (pop) begin
      h      = q[0];
      exp_ui = h.idx;
      exp_uo = res_taken;
      mis    = (res_taken != h.pred);
    end
    exp_mis = mis;
    if (mis) begin
      q.delete();
      ghr_m = ((h.ghr * 2) + int'(res_taken)) & MASK;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.idx  = model_idx(ghr_m, pred_pc);
        e.pred = pred_taken;
        e.ghr  = ghr_m;
        q.push_back(e);
        ghr_m = ((ghr_m * 2) + int'(pred_taken)) & MASK;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    model_clear();
    chk("rst_occupancy", int'(occupancy), 0);
    chk("rst_res_ready", int'(res_ready), 0);
    chk("rst_pred_ready", int'(pred_ready), 1);
    chk("rst_upd_valid", int'(upd_valid), 0);
    chk("rst_mispredict", int'(mispredict), 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit rt;
    model_clear();
    @(negedge clk);
    do_reset();

    // First push and a correct resolve of it.
    apply(1'b1, 32'h14, 1'b1, 1'b0, 1'b0);
`ifdef GHR_GSHARE_XOR_EN
    chk("first_lookup", int'(lookup_index), 5);
`else
    chk("first_lookup", int'(lookup_index), 0);
`endif
    advance();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("first_ghr", int'(lookup_index), 1);
    chk("first_occ", int'(occupancy), 1);
    advance();
    apply(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    advance();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("resolve_uv", int'(upd_valid), 1);
`ifdef GHR_GSHARE_XOR_EN
    chk("resolve_ui", int'(upd_index), 5);
`else
    chk("resolve_ui", int'(upd_index), 0);
`endif
    chk("resolve_uo", int'(upd_outcome), 1);
    chk("resolve_mis", int'(mispredict), 0);
    advance();

    // Five pushes into a four-deep FIFO.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, 32'(i * 4), 1'(i & 1), 1'b0, 1'b0);
      if (i == 4) begin
        chk("full_ready", int'(pred_ready), 0);
        chk("full_occ", int'(occupancy), 4);
      end
      advance();
    end
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("full_occ_after", int'(occupancy), 4);
    advance();

    // Mispredict with a same-cycle push that must be dropped.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
      advance();
    end
    apply(1'b1, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("ttt_ghr", int'(lookup_index), 7);
    advance();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("mis_pulse", int'(mispredict), 1);
    chk("mis_uv", int'(upd_valid), 1);
    chk("mis_occ", int'(occupancy), 0);
    chk("mis_ghr", int'(lookup_index), 0);
    advance();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("mis_one_cycle", int'(mispredict), 0);
    advance();

    // Simultaneous correct pop and push at occupancy 2.
    do_reset();
    apply(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    advance();
    apply(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    advance();
    apply(1'b1, 32'h0, 1'b1, 1'b1, 1'b1);
    advance();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("pp_occ", int'(occupancy), 2);
    chk("pp_ghr", int'(lookup_index), 5);
    advance();

    // History 0xA looked up with pc 0xFC.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 32'h0, 1'(~i & 1), 1'b0, 1'b0);
      advance();
    end
    apply(1'b0, 32'hFC, 1'b0, 1'b0, 1'b0);
`ifdef GHR_GSHARE_XOR_EN
    chk("pc_fc_lookup", int'(lookup_index), 5);
`else
    chk("pc_fc_lookup", int'(lookup_index), 10);
`endif
    advance();

    // Random traffic, with occasional asynchronous reset mid-flight.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 157 == 156) begin
        do_reset();
      end else begin
        rt = 1'($urandom_range(0, 1));
        if (q.size() != 0) rt = ($urandom_range(0, 3) == 0) ? ~q[0].pred : q[0].pred;
        apply(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), rt);
        advance();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
